// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the instruction ROM and queues {word, pc} pairs for decode.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky misalign_err output for unaligned redirect targets.
module instr_fetch_ctrl #(
    parameter int              AW       = 8,
    parameter int              DW       = 32,
    parameter int              DEPTH    = 2,
    parameter logic [AW-1:0]   RESET_PC = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    input  logic                      redirect,
    input  logic [AW-1:0]             redirect_pc,
    output logic [AW-1:0]             rom_addr,
    input  logic [DW-1:0]             rom_data,
    output logic [DW-1:0]             instr,
    output logic [AW-1:0]             instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    q_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                      misalign_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q;
    logic [DW-1:0]   word_q [DEPTH];
    logic [AW-1:0]   addr_q [DEPTH];

    logic            pop;
    logic            push;
    logic            fetching;
    logic [AW-1:0]   target_pc;

    assign target_pc = {redirect_pc[AW-1:2], 2'b00};
    assign fetching  = (state_q == S_FETCH) || (state_q == S_REDIR);

    always_comb begin
        pop      = valid_q && instr_ready;
        // A full queue still accepts a word when the head leaves in the same cycle.
        push     = fetching && fetch_en && !redirect && ((count_q != FULL) || pop);
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            // The head may be accepted this cycle, but everything queued is dropped anyway.
            state_d  = S_REDIR;
            pc_d     = target_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + AW'(4);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            unique case (state_q)
                S_IDLE:  state_d = fetch_en ? S_FETCH : S_IDLE;
                S_FETCH: state_d = fetch_en ? S_FETCH : S_IDLE;
                S_REDIR: state_d = fetch_en ? S_FETCH : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            if (push) begin
                word_q[wr_ptr_q] <= rom_data;
                addr_q[wr_ptr_q] <= pc_q;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            mis_q <= 1'b1;
        end
    end

    assign misalign_err = mis_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    assign rom_addr    = pc_q;
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];
    assign instr_valid = valid_q;
    assign q_count     = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand sequences and randomized traffic vs. a queue model.
module tb_instr_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  q_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    instr_fetch_ctrl #(.AW(8), .DW(32), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .q_count     (q_count)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte ROM, read big-endian: byte at addr is the most significant.
    logic [7:0] rom_b [256];
    always_comb rom_data = {rom_b[rom_addr], rom_b[rom_addr + 8'd1],
                            rom_b[rom_addr + 8'd2], rom_b[rom_addr + 8'd3]};

    function automatic logic [31:0] word_of(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
        return {rom_b[a], rom_b[a1], rom_b[a2], rom_b[a3]};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of fetched entries, a PC and a fetch mode.
    typedef struct { logic [31:0] w; logic [7:0] pc; } ent_t;
    ent_t       mq[$];
    logic [7:0] m_pc;
    int         m_mode;   // 0 idle, 1 fetching, 2 bubble after redirect
    logic       m_mis;

    task automatic model_reset();
        mq.delete();
        m_pc   = 8'h00;
        m_mode = 0;
        m_mis  = 1'b0;
    endtask

    task automatic model_edge(input logic fe, input logic rdy, input logic rd, input logic [7:0] rpc);
        bit   pop;
        bit   can;
        ent_t e;
        pop = (mq.size() > 0) && rdy;
        if (rd) begin
            mq.delete();
            m_pc   = {rpc[7:2], 2'b00};
            m_mode = 2;
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            can = (m_mode != 0) && fe && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (can) begin
                e.w  = word_of(m_pc);
                e.pc = m_pc;
                mq.push_back(e);
                m_pc = m_pc + 8'd4;
            end
            m_mode = fe ? 1 : 0;
        end
    endtask

    task automatic model_compare();
        chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
        chk("q_count", {30'd0, q_count}, 32'(mq.size()));
        chk("rom_addr", {24'd0, rom_addr}, {24'd0, m_pc});
        if (mq.size() > 0) begin
            chk("instr", instr, mq[0].w);
            chk("instr_pc", {24'd0, instr_pc}, {24'd0, mq[0].pc});
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare on the falling edge.
    task automatic step(input logic fe, input logic rdy, input logic rd, input logic [7:0] rpc);
        fetch_en    = fe;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge(fe, rdy, rd, rpc);
        @(negedge clk);
        model_compare();
    endtask

    typedef struct {
        logic       fe, rdy, rd;
        logic [7:0] rpc;
        logic       ev;
        logic [7:0] epc;
        logic [1:0] ecnt;
        logic [7:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rd, input logic [7:0] rpc,
                                input logic ev, input logic [7:0] epc, input logic [1:0] ecnt,
                                input logic [7:0] eaddr);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 256; i++) rom_b[i] = 8'($urandom);

        //          fe rdy rd rpc     ev epc    cnt addr
        tbl[0]  = mk(1, 1, 0, 8'h00,  0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(1, 1, 0, 8'h00,  1, 8'h00, 1, 8'h04);
        tbl[2]  = mk(1, 1, 0, 8'h00,  1, 8'h04, 1, 8'h08);
        tbl[3]  = mk(1, 1, 0, 8'h00,  1, 8'h08, 1, 8'h0C);
        tbl[4]  = mk(1, 0, 0, 8'h00,  1, 8'h08, 2, 8'h10);
        tbl[5]  = mk(1, 0, 0, 8'h00,  1, 8'h08, 2, 8'h10);
        tbl[6]  = mk(1, 0, 0, 8'h00,  1, 8'h08, 2, 8'h10);
        tbl[7]  = mk(1, 1, 0, 8'h00,  1, 8'h0C, 2, 8'h14);
        tbl[8]  = mk(1, 1, 0, 8'h00,  1, 8'h10, 2, 8'h18);
        tbl[9]  = mk(0, 1, 0, 8'h00,  1, 8'h14, 1, 8'h18);
        tbl[10] = mk(0, 1, 0, 8'h00,  0, 8'h00, 0, 8'h18);
        tbl[11] = mk(0, 0, 0, 8'h00,  0, 8'h00, 0, 8'h18);
        tbl[12] = mk(1, 0, 0, 8'h00,  0, 8'h00, 0, 8'h18);
        tbl[13] = mk(1, 0, 0, 8'h00,  1, 8'h18, 1, 8'h1C);
        tbl[14] = mk(1, 0, 0, 8'h00,  1, 8'h18, 2, 8'h20);
        tbl[15] = mk(1, 1, 1, 8'h40,  0, 8'h00, 0, 8'h40);
        tbl[16] = mk(1, 1, 0, 8'h00,  1, 8'h40, 1, 8'h44);
        tbl[17] = mk(1, 1, 0, 8'h00,  1, 8'h44, 1, 8'h48);
        tbl[18] = mk(1, 1, 1, 8'h43,  0, 8'h00, 0, 8'h40);
        tbl[19] = mk(1, 1, 0, 8'h00,  1, 8'h40, 1, 8'h44);

        rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset valid", {31'd0, instr_valid}, 32'd0);
        chk("reset q_count", {30'd0, q_count}, 32'd0);
        chk("reset rom_addr", {24'd0, rom_addr}, 32'h00);
        chk("reset instr", instr, 32'd0);
        chk("reset instr_pc", {24'd0, instr_pc}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("reset misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
        rst_n = 1'b1;

        // Directed vectors from reset: streaming, back-pressure, drain, redirect, unaligned redirect.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].fe, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("vec%0d valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d q_count", i), {30'd0, q_count}, {30'd0, tbl[i].ecnt});
            chk($sformatf("vec%0d rom_addr", i), {24'd0, rom_addr}, {24'd0, tbl[i].eaddr});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d instr_pc", i), {24'd0, instr_pc}, {24'd0, tbl[i].epc});
                chk($sformatf("vec%0d instr", i), instr, word_of(tbl[i].epc));
            end
`ifdef FETCH_ALIGN_CHECK_EN
            chk($sformatf("vec%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, i >= 18});
`endif
        end

        // Wrap-around past the top of the address space.
        step(1, 1, 1, 8'hF8);
        chk("wrap bubble", {31'd0, instr_valid}, 32'd0);
        step(1, 1, 0, 8'h00);
        chk("wrap pc0", {24'd0, instr_pc}, 32'hF8);
        step(1, 1, 0, 8'h00);
        chk("wrap pc1", {24'd0, instr_pc}, 32'hFC);
        step(1, 1, 0, 8'h00);
        chk("wrap pc2", {24'd0, instr_pc}, 32'h00);
        step(1, 1, 0, 8'h00);
        chk("wrap pc3", {24'd0, instr_pc}, 32'h04);
        chk("wrap valid", {31'd0, instr_valid}, 32'd1);

        // Asynchronous reset between clock edges, mid-stream.
        step(1, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async valid", {31'd0, instr_valid}, 32'd0);
        chk("async q_count", {30'd0, q_count}, 32'd0);
        chk("async rom_addr", {24'd0, rom_addr}, 32'h00);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("async misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Restart from the reset PC with decode stalled, then release it.
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("stall q_count", {30'd0, q_count}, 32'd2);
        chk("stall rom_addr", {24'd0, rom_addr}, 32'h08);
        chk("stall head", {24'd0, instr_pc}, 32'h00);
        step(1, 1, 0, 8'h00);
        chk("drain pc1", {24'd0, instr_pc}, 32'h04);
        step(1, 1, 0, 8'h00);
        chk("drain pc2", {24'd0, instr_pc}, 32'h08);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
